// File: rtl/i2c_pkg.sv
// Shared types for the I2C master: controller states, ACK levels and the
// per-bit strobe bundle handed to the datapath.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_START       = 4'd1,
    ST_ADDR        = 4'd2,
    ST_ADDR_ACK    = 4'd3,
    ST_WDATA       = 4'd4,
    ST_WDATA_ACK   = 4'd5,
    ST_RSTART      = 4'd6,
    ST_ADDR_RD     = 4'd7,
    ST_ADDR_RD_ACK = 4'd8,
    ST_RDATA       = 4'd9,
    ST_MACK        = 4'd10,
    ST_STOP        = 4'd11,
    ST_DONE        = 4'd12
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef struct packed {
    logic start_bit;
    logic stop_bit;
    logic send_addr;
    logic send_data;
    logic read_ack;
    logic send_ack;
    logic read_data;
  } strobe_t;

  localparam strobe_t STROBE_NONE = 7'b000_0000;

endpackage

// File: rtl/i2c_scl_gen.sv
// SCL divider: toggles SCL every HALF_PER clocks while running and flags each
// rise/fall in the same clock as the toggle. When disabled it parks SCL high.
module i2c_scl_gen #(
  parameter int HALF_PER = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic scl,
  output logic p_edge,
  output logic n_edge
);

  localparam int CW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [CW-1:0] WRAP = CW'(HALF_PER - 1);

  logic [CW-1:0] cnt_r;

  // Half-period counter; a disabled generator still completes a low half so SCL only stops high
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r  <= {CW{1'b0}};
      scl    <= 1'b1;
      p_edge <= 1'b0;
      n_edge <= 1'b0;
    end else if (!run && scl) begin
      cnt_r  <= {CW{1'b0}};
      p_edge <= 1'b0;
      n_edge <= 1'b0;
    end else if (cnt_r == WRAP) begin
      cnt_r  <= {CW{1'b0}};
      scl    <= ~scl;
      p_edge <= ~scl;
      n_edge <= scl;
    end else begin
      cnt_r  <= cnt_r + 1'b1;
      p_edge <= 1'b0;
      n_edge <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master control FSM: sequences START, address, write bytes, optional
// repeated-START read phase and STOP, driving the datapath strobes.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int MAX_RD     = 16,
  parameter int HALF_PER   = 125
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req,
  input  logic                            rw,
  input  logic [$clog2(DATA_WIDTH+1)-1:0] num_wr,
  input  logic [$clog2(MAX_RD+1)-1:0]     num_rd,
  input  logic                            ack_in,
  output logic                            scl,
  output logic                            p_edge,
  output logic                            n_edge,
  output logic                            start_bit,
  output logic                            stop_bit,
  output logic                            send_addr,
  output logic                            send_data,
  output logic                            read_ack,
  output logic                            send_ack,
  output logic                            read_data,
  output logic [1:0]                      repeated_start,
  output logic                            ack_i,
  output logic                            rd_valid,
  output logic                            busy,
  output logic                            done,
  output logic                            nack_err
);

  localparam int WW  = $clog2(DATA_WIDTH + 1);
  localparam int RW  = $clog2(MAX_RD + 1);
  localparam int WTW = $clog2(HALF_PER + 1);
  localparam logic [WTW-1:0] HP_LAST = WTW'(HALF_PER - 1);
  localparam logic [WTW-1:0] HQ_LAST = WTW'(HALF_PER / 2 - 1);

  state_t         state_r;
  state_t         wr_next_s;
  strobe_t        strobe_r;
  logic [1:0]     phase_r;
  logic [2:0]     bit_cnt_r;
  logic [WW-1:0]  byte_cnt_r;
  logic [RW-1:0]  rd_cnt_r;
  logic [WTW-1:0] wait_r;
  logic           rw_r;
  logic           run_r;

  i2c_scl_gen #(.HALF_PER(HALF_PER)) u_scl_gen (
    .clk    (clk),
    .rst    (rst),
    .run    (run_r),
    .scl    (scl),
    .p_edge (p_edge),
    .n_edge (n_edge)
  );

  assign start_bit = strobe_r.start_bit;
  assign stop_bit  = strobe_r.stop_bit;
  assign send_addr = strobe_r.send_addr;
  assign send_data = strobe_r.send_data;
  assign read_ack  = strobe_r.read_ack;
  assign send_ack  = strobe_r.send_ack;
  assign read_data = strobe_r.read_data;

  // Where to go once the address-W or a write byte has been ACKed
  always_comb begin
    if (byte_cnt_r != {WW{1'b0}}) begin
      wr_next_s = ST_WDATA;
    end else if (rw_r) begin
      wr_next_s = ST_RSTART;
    end else begin
      wr_next_s = ST_STOP;
    end
  end

  // Transaction sequencer; phase_r splits each state into wait-for-edge steps
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      strobe_r       <= STROBE_NONE;
      phase_r        <= 2'd0;
      bit_cnt_r      <= 3'd0;
      byte_cnt_r     <= {WW{1'b0}};
      rd_cnt_r       <= {RW{1'b0}};
      wait_r         <= {WTW{1'b0}};
      rw_r           <= 1'b0;
      run_r          <= 1'b0;
      repeated_start <= 2'b00;
      ack_i          <= NACK;
      rd_valid       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      nack_err       <= 1'b0;
    end else begin
      strobe_r.start_bit <= 1'b0;
      strobe_r.send_ack  <= 1'b0;
      rd_valid           <= 1'b0;
      done               <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            rw_r               <= rw;
            byte_cnt_r         <= num_wr;
            rd_cnt_r           <= (num_rd == {RW{1'b0}}) ? RW'(1) : num_rd;
            busy               <= 1'b1;
            nack_err           <= 1'b0;
            wait_r             <= {WTW{1'b0}};
            strobe_r.start_bit <= 1'b1;
            state_r            <= ST_START;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_START: begin
          if (wait_r == HP_LAST) begin
            run_r              <= 1'b1;
            bit_cnt_r          <= 3'd0;
            strobe_r.send_addr <= 1'b1;
            state_r            <= ST_ADDR;
          end else begin
            wait_r <= wait_r + 1'b1;
          end
        end
        ST_ADDR, ST_WDATA, ST_ADDR_RD: begin
          if (n_edge) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              strobe_r.send_addr <= 1'b0;
              strobe_r.send_data <= 1'b0;
              phase_r            <= 2'd0;
              case (state_r)
                ST_ADDR:  state_r <= ST_ADDR_ACK;
                ST_WDATA: begin
                  state_r <= ST_WDATA_ACK;
                  if (byte_cnt_r != {WW{1'b0}}) byte_cnt_r <= byte_cnt_r - 1'b1;
                end
                default:  state_r <= ST_ADDR_RD_ACK;
              endcase
            end
          end
        end
        ST_ADDR_ACK, ST_WDATA_ACK, ST_ADDR_RD_ACK: begin
          case (phase_r)
            2'd0: if (n_edge) begin
              strobe_r.send_ack <= 1'b1;
              strobe_r.read_ack <= 1'b1;
              ack_i             <= NACK;
              phase_r           <= 2'd1;
            end
            2'd1: if (p_edge) phase_r <= 2'd2;
            2'd2: begin
              strobe_r.read_ack <= 1'b0;
              phase_r           <= 2'd0;
              if (ack_in == NACK) begin
                nack_err <= 1'b1;
                state_r  <= ST_STOP;
              end else if (state_r == ST_ADDR_RD_ACK) begin
                state_r <= ST_RDATA;
              end else begin
                strobe_r.send_data <= (wr_next_s == ST_WDATA);
                state_r            <= wr_next_s;
              end
            end
            default: phase_r <= 2'd0;
          endcase
        end
        ST_RSTART: begin
          case (phase_r)
            2'd0: if (n_edge) begin
              run_r          <= 1'b0;
              repeated_start <= 2'b01;
              phase_r        <= 2'd1;
            end
            2'd1: if (p_edge) begin
              wait_r  <= {WTW{1'b0}};
              phase_r <= 2'd2;
            end
            2'd2: begin
              if (wait_r == HQ_LAST) begin
                repeated_start <= 2'b11;
                wait_r         <= {WTW{1'b0}};
                phase_r        <= 2'd3;
              end else begin
                wait_r <= wait_r + 1'b1;
              end
            end
            default: begin
              if (wait_r == HQ_LAST) begin
                repeated_start     <= 2'b00;
                run_r              <= 1'b1;
                bit_cnt_r          <= 3'd0;
                strobe_r.send_addr <= 1'b1;
                phase_r            <= 2'd0;
                state_r            <= ST_ADDR_RD;
              end else begin
                wait_r <= wait_r + 1'b1;
              end
            end
          endcase
        end
        ST_RDATA: begin
          if (phase_r == 2'd0) begin
            if (n_edge) begin
              strobe_r.send_ack  <= 1'b1;
              strobe_r.read_data <= 1'b1;
              ack_i              <= NACK;
              bit_cnt_r          <= 3'd0;
              phase_r            <= 2'd1;
            end
          end else if (p_edge) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              strobe_r.read_data <= 1'b0;
              rd_valid           <= 1'b1;
              phase_r            <= 2'd0;
              state_r            <= ST_MACK;
              if (rd_cnt_r != {RW{1'b0}}) rd_cnt_r <= rd_cnt_r - 1'b1;
            end
          end
        end
        ST_MACK: begin
          if (phase_r == 2'd0) begin
            if (n_edge) begin
              strobe_r.send_ack <= 1'b1;
              ack_i             <= (rd_cnt_r != {RW{1'b0}}) ? ACK : NACK;
              phase_r           <= 2'd1;
            end
          end else if (p_edge) begin
            phase_r <= 2'd0;
            state_r <= (rd_cnt_r != {RW{1'b0}}) ? ST_RDATA : ST_STOP;
          end
        end
        ST_STOP: begin
          case (phase_r)
            2'd0: if (n_edge) begin
              strobe_r.stop_bit <= 1'b1;
              run_r             <= 1'b0;
              phase_r           <= 2'd1;
            end
            2'd1: if (p_edge) begin
              wait_r  <= {WTW{1'b0}};
              phase_r <= 2'd2;
            end
            default: begin
              if (wait_r == HP_LAST) begin
                strobe_r.stop_bit <= 1'b0;
                busy              <= 1'b0;
                done              <= 1'b1;
                phase_r           <= 2'd0;
                state_r           <= ST_DONE;
              end else begin
                wait_r <= wait_r + 1'b1;
              end
            end
          endcase
        end
        ST_DONE: begin
          ack_i   <= NACK;
          state_r <= ST_IDLE;
        end
        default: begin
          strobe_r <= STROBE_NONE;
          run_r    <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
